aes_key_sched_ctrl: RTL and testbench

Synchronous sequencer that runs one AES-128 encrypt or decrypt job on the round datapath and steps the key-expansion block in lockstep with it. It accepts a job from the host by valid/ready, optionally loads a new master key, and pre-generates the key schedule when a decrypt needs it. It then issues one round command per key and returns completion or error by valid/ready. All key-expansion controls it drives are registered, glitch-free pulses, because that block treats them as edge-sensitive strobes.

---
 rtl/aes_key_sched_ctrl_if.sv | 37 +++
 rtl/aes_key_sched_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Host, key-expansion and round-datapath signals of the AES-128 key schedule sequencer.
interface aes_key_sched_ctrl_if;
    localparam int unsigned KEY_W = 128;
    localparam int unsigned IDX_W = 4;

    logic             req_valid;
    logic             req_ready;
    logic             req_dec;
    logic             req_new_key;
    logic [KEY_W-1:0] req_key;
    logic [KEY_W-1:0] key_out;
    logic             set_new_key;
    logic             start_enc;
    logic             ready_enc;
    logic             start_dec;
    logic             ready_dec;
    logic             rnd_start;
    logic [IDX_W-1:0] rnd_idx;
    logic             rnd_first;
    logic             rnd_last;
    logic             rnd_done;
    logic             out_valid;
    logic             out_ready;
    logic             out_err;

    modport master (
        output req_valid, req_dec, req_new_key, req_key, rnd_done, out_ready,
        input  req_ready, key_out, set_new_key, start_enc, ready_enc, start_dec, ready_dec,
               rnd_start, rnd_idx, rnd_first, rnd_last, out_valid, out_err
    );

    modport slave (
        input  req_valid, req_dec, req_new_key, req_key, rnd_done, out_ready,
        output req_ready, key_out, set_new_key, start_enc, ready_enc, start_dec, ready_dec,
               rnd_start, rnd_idx, rnd_first, rnd_last, out_valid, out_err
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequences one AES-128 job over the round datapath and steps key expansion in lockstep;
// every strobe and round command comes straight from a flop.
module aes_key_sched_ctrl #(
    parameter int unsigned NR      = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_key_sched_ctrl_if.slave   bus
);
    localparam int unsigned KEY_W = 128;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] NR_IDX  = IDX_W'(NR);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, GAP, KEYGEN, DSTART, GAP2, ISSUE, WAIT, STEP, SGAP, DONE
    } state_t;

    state_t             state;
    logic               dec_q;
    logic               dirty_q;
    logic               sched_valid;
    logic [KEY_W-1:0]   key_q;
    logic [IDX_W-1:0]   kg_cnt;
    logic [IDX_W-1:0]   rnd_cnt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               req_ready_q;
    logic               set_new_key_q;
    logic               start_enc_q;
    logic               ready_enc_q;
    logic               start_dec_q;
    logic               ready_dec_q;
    logic               rnd_start_q;
    logic [IDX_W-1:0]   rnd_idx_q;
    logic               rnd_first_q;
    logic               rnd_last_q;
    logic               out_valid_q;
    logic               out_err_q;

    logic [IDX_W-1:0]   issue_idx;
    logic               enter_issue;
    logic               accept;

    // rnd_cnt counts rounds in issue order; decrypt walks the index down from NR
    assign issue_idx   = dec_q ? (NR_IDX - rnd_cnt) : rnd_cnt;
    assign enter_issue = ((state == GAP) && !(dec_q && dirty_q)) || (state == GAP2) || (state == SGAP);
    assign accept      = bus.req_valid && req_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dec_q         <= 1'b0;
            dirty_q       <= 1'b0;
            sched_valid   <= 1'b0;
            key_q         <= '0;
            kg_cnt        <= '0;
            rnd_cnt       <= '0;
            wait_cnt      <= '0;
            req_ready_q   <= 1'b0;
            set_new_key_q <= 1'b0;
            start_enc_q   <= 1'b0;
            ready_enc_q   <= 1'b0;
            start_dec_q   <= 1'b0;
            ready_dec_q   <= 1'b0;
            rnd_start_q   <= 1'b0;
            rnd_idx_q     <= '0;
            rnd_first_q   <= 1'b0;
            rnd_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_err_q     <= 1'b0;
        end else begin
            set_new_key_q <= 1'b0;
            start_enc_q   <= 1'b0;
            ready_enc_q   <= 1'b0;
            start_dec_q   <= 1'b0;
            ready_dec_q   <= 1'b0;
            rnd_start_q   <= 1'b0;
            rnd_first_q   <= 1'b0;
            rnd_last_q    <= 1'b0;

            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        dec_q       <= bus.req_dec;
                        dirty_q     <= bus.req_new_key || !sched_valid;
                        rnd_cnt     <= '0;
                        kg_cnt      <= '0;
                        if (bus.req_new_key) begin
                            key_q       <= bus.req_key;
                            sched_valid <= 1'b0;
                        end
                        if (!bus.req_new_key && !sched_valid) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                        end else begin
                            state <= LOAD;
                            if (bus.req_new_key)  set_new_key_q <= 1'b1;
                            else if (!bus.req_dec) start_enc_q  <= 1'b1;
                            else                   start_dec_q  <= 1'b1;
                        end
                    end
                end
                LOAD: state <= GAP;
                GAP: begin
                    if (dec_q && dirty_q) begin
                        state       <= KEYGEN;
                        ready_enc_q <= 1'b1;
                        kg_cnt      <= IDX_W'(1);
                    end else begin
                        state <= ISSUE;
                    end
                end
                // Forward pass to produce the schedule: high/low pairs, NR pulses
                KEYGEN: begin
                    if (!ready_enc_q) begin
                        if (kg_cnt == NR_IDX) begin
                            state       <= DSTART;
                            start_dec_q <= 1'b1;
                            sched_valid <= 1'b1;
                        end else begin
                            ready_enc_q <= 1'b1;
                            kg_cnt      <= kg_cnt + IDX_W'(1);
                        end
                    end
                end
                DSTART: state <= GAP2;
                GAP2:   state <= ISSUE;
                ISSUE:  state <= WAIT;
                WAIT: begin
                    if (bus.rnd_done) begin
                        if (rnd_cnt == NR_IDX) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b0;
                            if (!dec_q && dirty_q) sched_valid <= 1'b1;
                        end else begin
                            state <= STEP;
                            if (dec_q) ready_dec_q <= 1'b1;
                            else       ready_enc_q <= 1'b1;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b1;
                        sched_valid <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                STEP: begin
                    state   <= SGAP;
                    rnd_cnt <= rnd_cnt + IDX_W'(1);
                end
                SGAP: state <= ISSUE;
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Round command registered on entry to ISSUE; timeout window restarts here
            if (enter_issue) begin
                rnd_start_q <= 1'b1;
                rnd_idx_q   <= issue_idx;
                rnd_first_q <= (rnd_cnt == '0);
                rnd_last_q  <= (rnd_cnt == NR_IDX);
                wait_cnt    <= '0;
            end
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.key_out     = key_q;
    assign bus.set_new_key = set_new_key_q;
    assign bus.start_enc   = start_enc_q;
    assign bus.ready_enc   = ready_enc_q;
    assign bus.start_dec   = start_dec_q;
    assign bus.ready_dec   = ready_dec_q;
    assign bus.rnd_start   = rnd_start_q;
    assign bus.rnd_idx     = rnd_idx_q;
    assign bus.rnd_first   = rnd_first_q;
    assign bus.rnd_last    = rnd_last_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_err     = out_err_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: per-job expected timelines built from latency
// arithmetic, compared against the DUT every cycle.
module tb_aes_key_sched_ctrl;
    localparam int NR   = 10;
    localparam int TO   = 8;
    localparam int MAXC = 256;

    typedef struct packed {
        logic       req_ready;
        logic       set_new_key;
        logic       start_enc;
        logic       ready_enc;
        logic       start_dec;
        logic       ready_dec;
        logic       rnd_start;
        logic [3:0] rnd_idx;
        logic       rnd_first;
        logic       rnd_last;
        logic       out_valid;
        logic       out_err;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_sched_ctrl_if bus();
    aes_key_sched_ctrl #(.NR(NR), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    obs_t         exp_q   [MAXC];
    logic         done_drv[MAXC];
    logic         ordy_drv[MAXC];
    int           exp_len;
    bit           sched_m;
    logic [127:0] key_m;
    int           n_chk  = 0;
    int           n_fail = 0;

    function automatic obs_t sample();
        obs_t o;
        o.req_ready   = bus.req_ready;
        o.set_new_key = bus.set_new_key;
        o.start_enc   = bus.start_enc;
        o.ready_enc   = bus.ready_enc;
        o.start_dec   = bus.start_dec;
        o.ready_dec   = bus.ready_dec;
        o.rnd_start   = bus.rnd_start;
        o.rnd_idx     = bus.rnd_idx;
        o.rnd_first   = bus.rnd_first;
        o.rnd_last    = bus.rnd_last;
        o.out_valid   = bus.out_valid;
        o.out_err     = bus.out_err;
        return o;
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_idle_reset(input string name, input logic rr);
        obs_t e;
        obs_t a;
        e = '0;
        e.req_ready = rr;
        a = sample();
        n_chk++;
        if (a !== e || bus.key_out !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h key %h expected %h key 0", name, a, bus.key_out, e);
        end
    endtask

    // Expected timeline of one job; cycle 0 is the cycle req_valid is presented.
    task automatic plan(input bit dec, input bit nk, input int to_round, input int hold, input bit noise);
        int  t;
        int  d;
        bit  err;
        for (int i = 0; i < MAXC; i++) begin
            exp_q[i]    = '0;
            done_drv[i] = 1'b0;
            ordy_drv[i] = 1'b1;
        end
        exp_q[0].req_ready = 1'b1;
        d   = -1;
        err = 1'b0;
        if (!nk && !sched_m) begin
            d   = 1;
            err = 1'b1;
        end else begin
            if (nk) begin
                exp_q[1].set_new_key = 1'b1;
                sched_m = 1'b0;
            end else if (dec) exp_q[1].start_dec = 1'b1;
            else              exp_q[1].start_enc = 1'b1;
            t = 3;
            if (dec && nk) begin
                for (int k = 0; k < NR; k++) exp_q[t + 2*k].ready_enc = 1'b1;
                t += 2*NR;
                exp_q[t].start_dec = 1'b1;
                sched_m = 1'b1;
                t += 2;
            end
            for (int r = 0; r <= NR && d < 0; r++) begin
                exp_q[t].rnd_start = 1'b1;
                exp_q[t].rnd_idx   = 4'(dec ? NR - r : r);
                exp_q[t].rnd_first = (r == 0);
                exp_q[t].rnd_last  = (r == NR);
                if (r == to_round) begin
                    d       = t + TO + 1;
                    err     = 1'b1;
                    sched_m = 1'b0;
                end else begin
                    done_drv[t+1] = 1'b1;
                    if (r == NR) begin
                        d = t + 2;
                        if (!dec && nk) sched_m = 1'b1;
                    end else begin
                        if (dec) exp_q[t+2].ready_dec = 1'b1;
                        else     exp_q[t+2].ready_enc = 1'b1;
                        if (noise) begin
                            done_drv[t+2] = 1'b1;
                            done_drv[t+3] = 1'b1;
                        end
                        t += 4;
                    end
                end
            end
        end
        for (int i = d; i <= d + hold; i++) begin
            exp_q[i].out_valid = 1'b1;
            exp_q[i].out_err   = err;
            ordy_drv[i]        = (i == d + hold);
        end
        exp_q[d + hold + 1].req_ready = 1'b1;
        exp_len = d + hold + 2;
    endtask

    task automatic run(input string name, input bit dec, input bit nk, input logic [127:0] key,
                       input int stop_at, output int first_ov);
        obs_t a;
        obs_t e;
        first_ov = -1;
        for (int c = 0; c < exp_len && c <= stop_at; c++) begin
            @(posedge clk);
            #1;
            bus.req_valid   = (c == 0);
            bus.req_dec     = dec;
            bus.req_new_key = nk;
            bus.req_key     = key;
            bus.rnd_done    = done_drv[c];
            bus.out_ready   = ordy_drv[c];
            if (c == 1 && nk) key_m = key;
            @(negedge clk);
            a = sample();
            e = exp_q[c];
            if (!e.rnd_start) begin
                a.rnd_idx   = '0;
                a.rnd_first = 1'b0;
                a.rnd_last  = 1'b0;
            end
            if (!e.out_valid) a.out_err = 1'b0;
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d outputs: got %h expected %h", name, c, a, e);
            end
            n_chk++;
            if (bus.key_out !== key_m) begin
                n_fail++;
                $display("FAIL %s cycle %0d key_out: got %h expected %h", name, c, bus.key_out, key_m);
            end
            if (first_ov < 0 && bus.out_valid === 1'b1) first_ov = c;
        end
        bus.req_valid = 1'b0;
        bus.rnd_done  = 1'b0;
    endtask

    initial begin
        int           ov;
        logic [127:0] k1;
        logic [127:0] k2;
        logic [127:0] junk;
        k1   = 128'h000102030405060708090a0b0c0d0e0f;
        k2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        junk = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        sched_m = 1'b0;
        key_m   = '0;
        rst = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_dec     = 1'b0;
        bus.req_new_key = 1'b0;
        bus.req_key     = '0;
        bus.rnd_done    = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset_values", 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_int("req_ready_after_release", int'(bus.req_ready), 1);

        // no schedule yet: immediate error, completion held while out_ready low
        plan(1'b0, 1'b0, -1, 5, 1'b0);
        run("nokey_err", 1'b0, 1'b0, junk, MAXC, ov);
        check_int("nokey_err_done_cycle", ov, 1);

        plan(1'b0, 1'b1, -1, 0, 1'b0);
        run("enc_newkey", 1'b0, 1'b1, k1, MAXC, ov);
        check_int("enc_newkey_done_cycle", ov, 45);
        n_chk++;
        if (bus.key_out !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_fail++;
            $display("FAIL key_out_literal: got %h expected 000102030405060708090a0b0c0d0e0f", bus.key_out);
        end

        // rnd_done pulsed outside WAIT must be ignored
        plan(1'b0, 1'b0, -1, 0, 1'b1);
        run("enc_cached_noise", 1'b0, 1'b0, junk, MAXC, ov);
        check_int("enc_cached_done_cycle", ov, 45);

        plan(1'b1, 1'b0, -1, 0, 1'b0);
        run("dec_cached", 1'b1, 1'b0, junk, MAXC, ov);
        check_int("dec_cached_done_cycle", ov, 45);

        plan(1'b1, 1'b1, -1, 2, 1'b0);
        run("dec_newkey", 1'b1, 1'b1, k2, MAXC, ov);
        check_int("dec_newkey_done_cycle", ov, 67);

        plan(1'b0, 1'b0, 4, 0, 1'b0);
        run("timeout_r4", 1'b0, 1'b0, junk, MAXC, ov);
        check_int("timeout_done_cycle", ov, 28);

        plan(1'b0, 1'b0, -1, 0, 1'b0);
        run("after_timeout_reject", 1'b0, 1'b0, junk, MAXC, ov);
        check_int("after_timeout_done_cycle", ov, 1);

        // reset while the first keygen pulse is high
        plan(1'b1, 1'b1, -1, 0, 1'b0);
        run("dec_abort", 1'b1, 1'b1, k1, 3, ov);
        check_int("abort_ready_enc_high", int'(bus.ready_enc), 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_reset("async_reset_midjob", 1'b0);
        sched_m = 1'b0;
        key_m   = '0;
        @(posedge clk);
        @(negedge clk);
        check_idle_reset("reset_held", 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_int("req_ready_after_abort", int'(bus.req_ready), 1);

        plan(1'b1, 1'b0, -1, 0, 1'b0);
        run("post_reset_reject", 1'b1, 1'b0, junk, MAXC, ov);
        check_int("post_reset_reject_cycle", ov, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
